// File: rtl/button_pkg.sv
// Shared constants, classifier state encoding and counter sizing for the
// push-button front end.
package button_pkg;

  localparam int DEBOUNCE_CYCLES_DEFAULT = 1_000_000;
  localparam int LONG_CYCLES_DEFAULT     = 100_000_000;
  localparam int PULSE_LEN_DEFAULT       = 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    HELD      = 2'd1,
    LONG_DONE = 2'd2
  } press_state_e;

  // Bits needed to hold the value max_count; never below one bit.
  function automatic int count_width(input int max_count);
    return (max_count < 1) ? 1 : $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/button_press_classifier_if.sv
// Raw button levels in, classified press events and debounced levels out.
interface button_press_classifier_if;

  logic       btn0;
  logic       btn1;
  logic       b0short;
  logic       b0long;
  logic       b1short;
  logic       b1long;
  logic [1:0] pressed;

  // Button source and event consumer side.
  modport master (
    output btn0, btn1,
    input  b0short, b0long, b1short, b1long, pressed
  );

  // Classifier side.
  modport slave (
    input  btn0, btn1,
    output b0short, b0long, b1short, b1long, pressed
  );

endinterface

// File: rtl/button_channel.sv
// One button: two-flop synchroniser, debouncer, short/long press classifier
// and event pulse stretcher. LONG_CYCLES must be at least 2.
module button_channel
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int LONG_CYCLES     = LONG_CYCLES_DEFAULT,
  parameter int PULSE_LEN       = PULSE_LEN_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic short_evt,
  output logic long_evt,
  output logic pressed
);

  localparam int DW = count_width(DEBOUNCE_CYCLES);
  localparam int HW = count_width(LONG_CYCLES);
  localparam int PW = count_width(PULSE_LEN);

  localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST  = HW'(LONG_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX   = HW'(LONG_CYCLES);
  localparam logic [PW-1:0] PULSE_LOAD = PW'(PULSE_LEN);

  localparam logic [1:0] ST_IDLE      = IDLE;
  localparam logic [1:0] ST_HELD      = HELD;
  localparam logic [1:0] ST_LONG_DONE = LONG_DONE;

  logic          sync_meta;
  logic          sync_q;
  logic          deb_q;
  logic [DW-1:0] deb_cnt;
  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [HW-1:0] hold_cnt;
  logic [HW-1:0] hold_nxt;
  logic          fire_short;
  logic          fire_long;
  logic [PW-1:0] pulse_cnt;
  logic          pulse_long;

  // NOTE: non-blocking assignments let both flops sample the pre-edge
  // values, so the chain really is two stages deep.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_meta <= 1'b0;
      sync_q    <= 1'b0;
    end else begin
      sync_meta <= btn;
      sync_q    <= sync_meta;
    end
  end

  // Counts consecutive cycles the synchronised level disagrees with the
  // accepted level; the final counted cycle flips the level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      deb_q   <= 1'b0;
      deb_cnt <= '0;
    end else if (sync_q == deb_q) begin
      deb_cnt <= '0;
    end else if (deb_cnt == DEB_LAST) begin
      deb_q   <= sync_q;
      deb_cnt <= '0;
    end else begin
      deb_cnt <= deb_cnt + DW'(1);
    end
  end

  assign pressed = deb_q;

  // NOTE: every output of this block gets a default first so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_nxt  = state;
    hold_nxt   = hold_cnt;
    fire_short = 1'b0;
    fire_long  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        hold_nxt = '0;
        if (deb_q) begin
          // The cycle the rise is seen already counts as one held cycle.
          state_nxt = ST_HELD;
          hold_nxt  = HW'(1);
        end
      end
      ST_HELD: begin
        // Reaching the long threshold wins over a release seen on the same
        // edge, so a press is never reported as both.
        if (hold_cnt == HOLD_LAST) begin
          fire_long = 1'b1;
          state_nxt = ST_LONG_DONE;
          hold_nxt  = HOLD_MAX;
        end else if (!deb_q) begin
          fire_short = 1'b1;
          state_nxt  = ST_IDLE;
          hold_nxt   = '0;
        end else begin
          hold_nxt = hold_cnt + HW'(1);
        end
      end
      ST_LONG_DONE: begin
        if (!deb_q) begin
          state_nxt = ST_IDLE;
          hold_nxt  = '0;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        hold_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      hold_cnt <= '0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_nxt;
    end
  end

  // A new event always restarts the pulse and takes over its type.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pulse_cnt  <= '0;
      pulse_long <= 1'b0;
    end else if (fire_short || fire_long) begin
      pulse_cnt  <= PULSE_LOAD;
      pulse_long <= fire_long;
    end else if (pulse_cnt != '0) begin
      pulse_cnt <= pulse_cnt - PW'(1);
    end
  end

  assign short_evt = (pulse_cnt != '0) && !pulse_long;
  assign long_evt  = (pulse_cnt != '0) &&  pulse_long;

endmodule

// File: rtl/button_press_classifier.sv
// Watch front end: two independent button channels producing stretched
// short/long press events and the debounced levels.
module button_press_classifier
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int LONG_CYCLES     = LONG_CYCLES_DEFAULT,
  parameter int PULSE_LEN       = PULSE_LEN_DEFAULT
) (
  input  logic                        clk,
  input  logic                        rst,
  button_press_classifier_if.slave    btn_if
);

  logic pressed0;
  logic pressed1;

  button_channel #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .LONG_CYCLES     (LONG_CYCLES),
    .PULSE_LEN       (PULSE_LEN)
  ) u_ch0 (
    .clk       (clk),
    .rst       (rst),
    .btn       (btn_if.btn0),
    .short_evt (btn_if.b0short),
    .long_evt  (btn_if.b0long),
    .pressed   (pressed0)
  );

  button_channel #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .LONG_CYCLES     (LONG_CYCLES),
    .PULSE_LEN       (PULSE_LEN)
  ) u_ch1 (
    .clk       (clk),
    .rst       (rst),
    .btn       (btn_if.btn1),
    .short_evt (btn_if.b1short),
    .long_evt  (btn_if.b1long),
    .pressed   (pressed1)
  );

  assign btn_if.pressed = {pressed1, pressed0};

endmodule
